// File: rtl/draw_ball_if.sv
// VGA pixel stream into and out of the ball renderer, plus the latched-position inputs.
// master drives the incoming stream and ball position; slave is the renderer.
interface draw_ball_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] xpos_ball;
    logic [11:0] ypos_ball;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output xpos_ball, ypos_ball,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input  xpos_ball, ypos_ball,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );
endinterface

// File: rtl/draw_ball.sv
// Overlays a filled disc on the VGA stream through a fixed 3-stage pipeline; position latched per frame.
// Define BALL_OUTLINE_EN to paint a 1-pixel OUTLINE_COLOR rim around the disc.
module draw_ball #(
    parameter int unsigned RADIUS_BALL   = 10,
    parameter logic [11:0] BALL_COLOR    = 12'h0_0_0,
    parameter logic [11:0] OUTLINE_COLOR = 12'hF_F_F
) (
    input  logic        clk_in,
    input  logic        rst,
    draw_ball_if.slave  vga
);

    localparam logic [26:0] R_SQ = 27'(RADIUS_BALL * RADIUS_BALL);
`ifdef BALL_OUTLINE_EN
    localparam logic [26:0] R_IN_SQ = 27'((RADIUS_BALL - 1) * (RADIUS_BALL - 1));
`endif

    logic [11:0] xl, yl;
    logic        vblnk_prev;

    logic signed [12:0] dx_s1, dy_s1;
    logic [10:0]        hcount_s1, vcount_s1;
    logic [3:0]         sync_s1;
    logic [11:0]        rgb_s1;

    logic [25:0]        dx2_s2, dy2_s2;
    logic [10:0]        hcount_s2, vcount_s2;
    logic [3:0]         sync_s2;
    logic [11:0]        rgb_s2;

    logic signed [25:0] dx_ext, dy_ext, dx_sq, dy_sq;
    logic [26:0]        sum;
    logic [11:0]        rgb_next;

    // Position is taken only on the rising edge of vertical blanking so a frame is never torn.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            xl         <= 12'd487;
            yl         <= 12'd362;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vga.vblnk_in;
            if (vga.vblnk_in && !vblnk_prev) begin
                xl <= vga.xpos_ball;
                yl <= vga.ypos_ball;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            dx_s1     <= '0;
            dy_s1     <= '0;
            hcount_s1 <= '0;
            vcount_s1 <= '0;
            sync_s1   <= '0;
            rgb_s1    <= '0;
        end else begin
            dx_s1     <= $signed({2'b00, vga.hcount_in}) - $signed({1'b0, xl});
            dy_s1     <= $signed({2'b00, vga.vcount_in}) - $signed({1'b0, yl});
            hcount_s1 <= vga.hcount_in;
            vcount_s1 <= vga.vcount_in;
            sync_s1   <= {vga.hsync_in, vga.vsync_in, vga.hblnk_in, vga.vblnk_in};
            rgb_s1    <= vga.rgb_in;
        end
    end

    assign dx_ext = 26'(dx_s1);
    assign dy_ext = 26'(dy_s1);
    assign dx_sq  = dx_ext * dx_ext;
    assign dy_sq  = dy_ext * dy_ext;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            dx2_s2    <= '0;
            dy2_s2    <= '0;
            hcount_s2 <= '0;
            vcount_s2 <= '0;
            sync_s2   <= '0;
            rgb_s2    <= '0;
        end else begin
            dx2_s2    <= $unsigned(dx_sq);
            dy2_s2    <= $unsigned(dy_sq);
            hcount_s2 <= hcount_s1;
            vcount_s2 <= vcount_s1;
            sync_s2   <= sync_s1;
            rgb_s2    <= rgb_s1;
        end
    end

    assign sum = {1'b0, dx2_s2} + {1'b0, dy2_s2};

    // sync_s2 = {hsync, vsync, hblnk, vblnk}; blanking is never painted.
    always_comb begin
        rgb_next = rgb_s2;
        if (!sync_s2[1] && !sync_s2[0]) begin
`ifdef BALL_OUTLINE_EN
            if (sum <= R_IN_SQ)
                rgb_next = BALL_COLOR;
            else if (sum <= R_SQ)
                rgb_next = OUTLINE_COLOR;
`else
            if (sum <= R_SQ)
                rgb_next = BALL_COLOR;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            vga.hcount_out <= '0;
            vga.vcount_out <= '0;
            vga.hsync_out  <= 1'b0;
            vga.vsync_out  <= 1'b0;
            vga.hblnk_out  <= 1'b0;
            vga.vblnk_out  <= 1'b0;
            vga.rgb_out    <= '0;
        end else begin
            vga.hcount_out <= hcount_s2;
            vga.vcount_out <= vcount_s2;
            vga.hsync_out  <= sync_s2[3];
            vga.vsync_out  <= sync_s2[2];
            vga.hblnk_out  <= sync_s2[1];
            vga.vblnk_out  <= sync_s2[0];
            vga.rgb_out    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_ball.sv
// Randomized and directed bench for draw_ball against a distance-rule reference model.
module tb_draw_ball;

    localparam int          RADIUS  = 10;
    localparam logic [11:0] BALL    = 12'h000;
    localparam logic [11:0] OUTLINE = 12'hFFF;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_vec  = 0;
    int   n_err  = 0;

    draw_ball_if vif ();

    draw_ball dut (
        .clk_in (clk_in),
        .rst    (rst),
        .vga    (vif)
    );

    always #5 clk_in = ~clk_in;

    vec_t pipe [3];
    int   mxl = 487;
    int   myl = 362;
    bit   mprev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int h, input int v, input int xc, input int yc,
                                            input bit blank, input logic [11:0] rgb_i);
        int sum;
        sum = (h - xc) * (h - xc) + (v - yc) * (v - yc);
        if (blank) return rgb_i;
`ifdef BALL_OUTLINE_EN
        if (sum <= (RADIUS - 1) * (RADIUS - 1)) return BALL;
        if (sum <= RADIUS * RADIUS) return OUTLINE;
`else
        if (sum <= RADIUS * RADIUS) return BALL;
`endif
        return rgb_i;
    endfunction

    task automatic drive(input int h, input int v, input bit hb, input bit vb, input logic [11:0] rgb);
        vif.hcount_in = 11'(h);
        vif.vcount_in = 11'(v);
        vif.hsync_in  = 1'($urandom);
        vif.vsync_in  = 1'($urandom);
        vif.hblnk_in  = hb;
        vif.vblnk_in  = vb;
        vif.rgb_in    = rgb;
    endtask

    // One clock: advance the reference delay line, then compare what emerges.
    task automatic step();
        vec_t cur;
        vec_t got;
        @(posedge clk_in);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            mxl   = 487;
            myl   = 362;
            mprev = 1'b0;
        end else begin
            cur.h   = vif.hcount_in;
            cur.v   = vif.vcount_in;
            cur.hs  = vif.hsync_in;
            cur.vs  = vif.vsync_in;
            cur.hb  = vif.hblnk_in;
            cur.vb  = vif.vblnk_in;
            cur.rgb = ref_rgb(int'(vif.hcount_in), int'(vif.vcount_in), mxl, myl,
                              vif.hblnk_in || vif.vblnk_in, vif.rgb_in);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = cur;
            if (vif.vblnk_in && !mprev) begin
                mxl = int'(vif.xpos_ball);
                myl = int'(vif.ypos_ball);
            end
            mprev = vif.vblnk_in;
        end
        #1;
        got = {vif.hcount_out, vif.vcount_out, vif.hsync_out, vif.vsync_out,
               vif.hblnk_out, vif.vblnk_out, vif.rgb_out};
        chk("timing", 64'(got[37:12]), 64'(pipe[2][37:12]));
        chk("rgb", 64'(vif.rgb_out), 64'(pipe[2].rgb));
    endtask

    function automatic logic [11:0] rnd_rgb();
        return 12'($urandom_range(1, 4095));
    endfunction

    // Drive one pixel, push two filler pixels, and check the pixel's colour against a hand constant.
    task automatic probe(input string tag, input int h, input int v, input bit hb,
                         input logic [11:0] rgb, input logic [11:0] exp_rgb);
        drive(h, v, hb, 1'b0, rgb);
        step();
        drive(1000, 900, 1'b0, 1'b0, rnd_rgb());
        step();
        drive(1001, 900, 1'b0, 1'b0, rnd_rgb());
        step();
        chk(tag, 64'(vif.rgb_out), 64'(exp_rgb));
        chk({tag, "_h"}, 64'(vif.hcount_out), 64'(h));
    endtask

    task automatic latch_ball(input int x, input int y);
        vif.xpos_ball = 12'(x);
        vif.ypos_ball = 12'(y);
        for (int i = 0; i < 4; i++) begin
            drive(100 + i, 600, 1'b0, i < 2, rnd_rgb());
            step();
        end
    endtask

    logic [11:0] r;

    initial begin
        vif.xpos_ball = 12'd487;
        vif.ypos_ball = 12'd362;
        drive(0, 0, 1'b0, 1'b0, 12'h000);
        rst = 1'b1;
        step();
        step();
        chk("reset_rgb", 64'(vif.rgb_out), 64'd0);
        chk("reset_hcount", 64'(vif.hcount_out), 64'd0);
        rst = 1'b0;

        // Window scan around the default centre.
        for (int y = 345; y < 380; y++)
            for (int x = 470; x < 505; x++) begin
                drive(x, y, 1'b0, 1'b0, rnd_rgb());
                step();
            end

        probe("centre", 487, 362, 1'b0, 12'h123, BALL);
`ifdef BALL_OUTLINE_EN
        probe("rim_100", 497, 362, 1'b0, 12'h456, OUTLINE);
        probe("inner_81", 496, 362, 1'b0, 12'h456, BALL);
`else
        probe("edge_100", 497, 362, 1'b0, 12'h456, BALL);
`endif
        probe("out_121", 498, 362, 1'b0, 12'h789, 12'h789);
        probe("out_128", 495, 370, 1'b0, 12'h9A5, 12'h9A5);
        probe("hblank", 487, 362, 1'b1, 12'hABC, 12'hABC);

        // Mid-frame position change must wait for the next vblank edge.
        for (int x = 0; x < 20; x++) begin
            drive(x, 100, 1'b0, 1'b0, rnd_rgb());
            step();
        end
        vif.xpos_ball = 12'd300;
        probe("old_frame_487", 487, 362, 1'b0, 12'h321, BALL);
        probe("old_frame_300", 300, 362, 1'b0, 12'h321, 12'h321);
        latch_ball(300, 362);
        probe("new_frame_300", 300, 362, 1'b0, 12'h654, BALL);
        probe("new_frame_487", 487, 362, 1'b0, 12'h654, 12'h654);

        // Disc clipped at the top-left corner, and nothing near the right edge.
        latch_ball(5, 5);
        probe("corner_50", 0, 0, 1'b0, 12'h777, BALL);
        probe("corner_106", 0, 14, 1'b0, 12'h777, 12'h777);
        for (int y = 0; y < 16; y++)
            for (int x = 2040; x < 2048; x++) begin
                drive(x, y, 1'b0, 1'b0, rnd_rgb());
                step();
            end
        probe("far_edge", 2047, 5, 1'b0, 12'h5A5, 12'h5A5);
        latch_ball(4000, 362);
        probe("beyond_2047", 2047, 362, 1'b0, 12'h3C3, 12'h3C3);

        // One-cycle reset mid-line.
        vif.xpos_ball = 12'd5;
        vif.ypos_ball = 12'd5;
        drive(200, 50, 1'b0, 1'b0, rnd_rgb());
        step();
        rst = 1'b1;
        drive(201, 50, 1'b0, 1'b0, rnd_rgb());
        step();
        chk("rst_rgb", 64'(vif.rgb_out), 64'd0);
        chk("rst_vcount", 64'(vif.vcount_out), 64'd0);
        rst = 1'b0;
        probe("post_rst_487", 487, 362, 1'b0, 12'hBEE, BALL);
        probe("post_rst_5", 5, 5, 1'b0, 12'hBEE, 12'hBEE);

        // Random traffic with random blanking, vblank edges and positions.
        for (int n = 0; n < 20000; n++) begin
            int h, v;
            if ($urandom_range(0, 99) < 3) begin
                vif.xpos_ball = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 2100));
                vif.ypos_ball = 12'($urandom_range(0, 1200));
            end
            if ($urandom_range(0, 1) == 1) begin
                h = mxl + $urandom_range(0, 30) - 15;
                v = myl + $urandom_range(0, 30) - 15;
                if (h < 0) h = 0;
                if (h > 2047) h = 2047;
                if (v < 0) v = 0;
                if (v > 2047) v = 2047;
            end else begin
                h = $urandom_range(0, 2047);
                v = $urandom_range(0, 2047);
            end
            r = rnd_rgb();
            drive(h, v, $urandom_range(0, 9) == 0,
                  (n % 500) < 20 ? 1'b1 : ($urandom_range(0, 199) == 0), r);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
